tl_phase_sequencer: RTL and testbench

- Registered phase controller for the two-approach intersection: main road (lights 1/3) and side road (lights 2/4).
- Owns the phase state register and the per-phase countdown.
- Loads the per-phase delays and grants the side road only on demand from car sensors (or a pedestrian request).
- Drives both light pairs directly; replaces the externally fed state/timer pairing at top level.

---
 rtl/tl_phase_sequencer.sv | 117 +++++++++++
 tb/tb_tl_phase_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tl_phase_sequencer.sv
// rtl/tl_phase_sequencer.sv - registered phase controller for a two-approach intersection
// Optional pedestrian request latch enabled by defining TL_PED_EN.
module tl_phase_sequencer #(
  parameter int CW = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_enable,
  input  logic          i_car2,
  input  logic          i_car4,
  input  logic          i_ped_req,
  input  logic [CW-1:0] i_d1,
  input  logic [CW-1:0] i_d2,
  input  logic [CW-1:0] i_d3,
  input  logic [CW-1:0] i_d4,
  output logic [1:0]    o_state,
  output logic [1:0]    o_l13,
  output logic [1:0]    o_l24,
  output logic [CW-1:0] o_remaining,
  output logic          o_ped_ack
);

  typedef enum logic [1:0] {
    G13 = 2'b00,
    Y13 = 2'b01,
    G24 = 2'b10,
    Y24 = 2'b11
  } phase_t;

  phase_t        r_state;
  logic [CW-1:0] r_remaining;
  logic          w_ped_pend;
  logic          w_demand;
  logic          w_g24_entry;

  // A zero delay still occupies one cycle, so the load value is max(d,1)-1.
  function automatic logic [CW-1:0] f_load(input logic [CW-1:0] d);
    return (d == '0) ? '0 : d - CW'(1);
  endfunction

  assign w_demand    = i_car2 | i_car4 | w_ped_pend;
  assign w_g24_entry = i_enable && (r_state == Y13) && (r_remaining == '0);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= G13;
      r_remaining <= f_load(i_d1);
    end else if (i_enable) begin
      if (r_remaining != '0) begin
        r_remaining <= r_remaining - CW'(1);
      end else begin
        case (r_state)
          G13: if (w_demand) begin
            r_state     <= Y13;
            r_remaining <= f_load(i_d2);
          end
          Y13: begin
            r_state     <= G24;
            r_remaining <= f_load(i_d3);
          end
          G24: begin
            r_state     <= Y24;
            r_remaining <= f_load(i_d4);
          end
          default: begin
            r_state     <= G13;
            r_remaining <= f_load(i_d1);
          end
        endcase
      end
    end
  end

`ifdef TL_PED_EN
  logic r_ped_pend;
  logic r_ped_ack;

  // The latch keeps listening while frozen; a request on the G24 entry edge is already served.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_ped_pend <= 1'b0;
      r_ped_ack  <= 1'b0;
    end else begin
      r_ped_ack <= w_g24_entry & (r_ped_pend | i_ped_req);
      if (w_g24_entry) begin
        r_ped_pend <= 1'b0;
      end else if (i_ped_req) begin
        r_ped_pend <= 1'b1;
      end
    end
  end

  assign w_ped_pend = r_ped_pend;
  assign o_ped_ack  = r_ped_ack;
`else
  logic w_unused_ped;

  assign w_unused_ped = i_ped_req ^ w_g24_entry;
  assign w_ped_pend   = 1'b0;
  assign o_ped_ack    = 1'b0;
`endif

  assign o_state     = r_state;
  assign o_remaining = r_remaining;

  always_comb begin
    o_l13 = 2'b00;
    o_l24 = 2'b00;
    case (r_state)
      G13:     o_l13 = 2'b10;
      Y13:     o_l13 = 2'b01;
      G24:     o_l24 = 2'b10;
      default: o_l24 = 2'b01;
    endcase
  end

endmodule

// File: tb/tb_tl_phase_sequencer.sv
// tb/tb_tl_phase_sequencer.sv - randomized model-checked bench for tl_phase_sequencer
// Honors TL_PED_EN in its reference model.
module tb_tl_phase_sequencer;

  logic       clk = 1'b0;
  logic       reset, enable, car2, car4, ped_req;
  logic [3:0] d1, d2, d3, d4;
  logic [1:0] state, l13, l24;
  logic [3:0] remaining;
  logic       ped_ack;

  int checks   = 0;
  int failures = 0;

  // Model: phase index, cycles spent in phase, phase length fixed at entry.
  int m_phase, m_elapsed, m_len;
  bit m_pend, m_ack;

  tl_phase_sequencer #(.CW(4)) dut (
    .i_clk(clk), .i_reset(reset), .i_enable(enable),
    .i_car2(car2), .i_car4(car4), .i_ped_req(ped_req),
    .i_d1(d1), .i_d2(d2), .i_d3(d3), .i_d4(d4),
    .o_state(state), .o_l13(l13), .o_l24(l24),
    .o_remaining(remaining), .o_ped_ack(ped_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  function automatic int dur(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic int delay_of(input int p);
    case (p)
      0: return dur(int'(d1));
      1: return dur(int'(d2));
      2: return dur(int'(d3));
      default: return dur(int'(d4));
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit served;
    bit ped_on;
    served = 1'b0;
`ifdef TL_PED_EN
    ped_on = 1'b1;
`else
    ped_on = 1'b0;
`endif
    if (!reset) begin
      m_phase = 0; m_len = delay_of(0); m_elapsed = 0; m_pend = 0; m_ack = 0;
    end else begin
      m_ack = 0;
      if (enable) begin
        if (m_elapsed < m_len - 1) begin
          m_elapsed++;
        end else if (m_phase != 0 || car2 || car4 || m_pend) begin
          served    = (m_phase == 1);
          m_phase   = (m_phase + 1) % 4;
          m_len     = delay_of(m_phase);
          m_elapsed = 0;
        end
      end
      if (ped_on) begin
        if (served) begin
          m_ack  = m_pend | ped_req;
          m_pend = 0;
        end else if (ped_req) begin
          m_pend = 1;
        end
      end
    end
  endtask

  task automatic compare();
    int e13, e24;
    e13 = (m_phase == 0) ? 2 : (m_phase == 1) ? 1 : 0;
    e24 = (m_phase == 2) ? 2 : (m_phase == 3) ? 1 : 0;
    chk("state", int'(state), m_phase);
    chk("remaining", int'(remaining), m_len - 1 - m_elapsed);
    chk("l13", int'(l13), e13);
    chk("l24", int'(l24), e24);
    chk("ped_ack", int'(ped_ack), int'(m_ack));
  endtask

  task automatic tick(input logic rs, input logic en, input logic c2, input logic c4,
                      input logic pr, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] d);
    reset = rs; enable = en; car2 = c2; car4 = c4; ped_req = pr;
    d1 = a; d2 = b; d3 = c; d4 = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  int exp_st[10] = '{0, 0, 1, 1, 2, 2, 2, 2, 3, 0};
  int exp_rm[10] = '{1, 0, 1, 0, 3, 2, 1, 0, 0, 2};

  initial begin
    m_phase = 0; m_elapsed = 0; m_len = 1; m_pend = 0; m_ack = 0;

    // Reset with d1=3, then idle main green.
    tick(0, 1, 0, 0, 0, 3, 2, 4, 1);
    chk("lit_reset_state", int'(state), 0);
    chk("lit_reset_rem", int'(remaining), 2);
    chk("lit_reset_l13", int'(l13), 2);
    chk("lit_reset_l24", int'(l24), 0);
    for (int i = 0; i < 10; i++) tick(1, 1, 0, 0, 0, 3, 2, 4, 1);
    chk("lit_idle_state", int'(state), 0);
    chk("lit_idle_rem", int'(remaining), 0);

    // One-cycle car4 pulse while idling.
    tick(1, 1, 0, 1, 0, 3, 2, 4, 1);
    chk("lit_car4_state", int'(state), 1);
    chk("lit_car4_rem", int'(remaining), 1);

    // Full cycle with car2 held from reset.
    tick(0, 1, 1, 0, 0, 3, 2, 4, 1);
    for (int i = 0; i < 10; i++) begin
      tick(1, 1, 1, 0, 0, 3, 2, 4, 1);
      chk("lit_cycle_state", int'(state), exp_st[i]);
      chk("lit_cycle_rem", int'(remaining), exp_rm[i]);
    end

    // d2=0 gives a single yellow cycle.
    tick(1, 1, 1, 0, 0, 3, 0, 4, 1);
    tick(1, 1, 1, 0, 0, 3, 0, 4, 1);
    tick(1, 1, 1, 0, 0, 3, 0, 4, 1);
    chk("lit_y0_state", int'(state), 1);
    chk("lit_y0_rem", int'(remaining), 0);
    tick(1, 1, 1, 0, 0, 3, 0, 4, 1);
    chk("lit_g24_state", int'(state), 2);
    chk("lit_g24_rem", int'(remaining), 3);

    // Freeze mid-G24 for five cycles.
    tick(1, 1, 1, 0, 0, 3, 2, 4, 1);
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, 1, 0, 0, 3, 2, 9, 1);
      chk("lit_frz_state", int'(state), 2);
      chk("lit_frz_rem", int'(remaining), 2);
    end
    tick(1, 1, 1, 0, 0, 3, 2, 4, 1);
    tick(1, 1, 1, 0, 0, 3, 2, 4, 1);
    chk("lit_late_state", int'(state), 2);
    tick(1, 1, 1, 0, 0, 3, 2, 4, 1);
    chk("lit_y24_state", int'(state), 3);

    // Reset during Y24 returns straight to main green.
    tick(0, 1, 1, 0, 0, 3, 2, 4, 1);
    chk("lit_rst_y24_state", int'(state), 0);
    chk("lit_rst_y24_rem", int'(remaining), 2);

    // Pedestrian request with no cars.
    tick(0, 1, 0, 0, 0, 1, 1, 4, 1);
    tick(1, 1, 0, 0, 0, 1, 1, 4, 1);
    tick(1, 1, 0, 0, 1, 1, 1, 4, 1);
    chk("lit_ped_hold", int'(state), 0);
    tick(1, 1, 0, 0, 0, 1, 1, 4, 1);
`ifdef TL_PED_EN
    chk("lit_ped_y13", int'(state), 1);
`else
    chk("lit_ped_y13", int'(state), 0);
`endif
    tick(1, 1, 0, 0, 0, 1, 1, 4, 1);
`ifdef TL_PED_EN
    chk("lit_ped_g24", int'(state), 2);
    chk("lit_ped_ack1", int'(ped_ack), 1);
`else
    chk("lit_ped_g24", int'(state), 0);
    chk("lit_ped_ack1", int'(ped_ack), 0);
`endif
    tick(1, 1, 0, 0, 0, 1, 1, 4, 1);
    chk("lit_ped_ack0", int'(ped_ack), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      tick(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 99) < 85),
           ($urandom_range(0, 99) < 8),
           ($urandom_range(0, 99) < 8),
           ($urandom_range(0, 99) < 5),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
